regfile_wr_sched: RTL and testbench

Write-port scheduler and hazard scoreboard for the 8 x 16-bit register file. Three writeback sources share the file's single general write port and its dedicated R7 port: ALU writeback, load writeback and the multi-register load sequencer. The block arbitrates round-robin between them, steers address-7 writes to the R7 port, and tracks pending destination registers so decode can stall on read-after-write hazards.

---
 rtl/regfile_wr_sched_if.sv | 14 +
 rtl/regfile_wr_sched.sv | 138 +++++++++++++
 tb/tb_regfile_wr_sched.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_wr_sched_if.sv
// Writeback request bus shared by the ALU, load and multi-load sources.
// Requester i occupies slice i of req_addr/req_data; req_ready is a one-hot grant.
interface regfile_wr_sched_if #(
   parameter int DW = 16,
   parameter int AW = 3
);
   logic [2:0]      req_valid;
   logic [3*AW-1:0] req_addr;
   logic [3*DW-1:0] req_data;
   logic [2:0]      req_ready;

   modport master (output req_valid, output req_addr, output req_data, input req_ready);
   modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/regfile_wr_sched.sv
// Round-robin write-port scheduler for the register file, with R7 steering and a
// pending-destination scoreboard that drives the decode RAW stall.
module regfile_wr_sched #(
   parameter int DW = 16,
   parameter int AW = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   regfile_wr_sched_if.slave    req,
   output logic                 write_en,
   output logic [AW-1:0]        wr,
   output logic [DW-1:0]        data_in,
   output logic                 R7_en,
   output logic [DW-1:0]        R7_in,
   input  logic                 claim_en,
   input  logic [AW-1:0]        claim_addr,
   input  logic                 flush,
   input  logic [AW-1:0]        sr1,
   input  logic [AW-1:0]        sr2,
   input  logic                 use1,
   input  logic                 use2,
   output logic                 stall,
   output logic [(1<<AW)-1:0]   pending
);
   localparam logic [AW-1:0] R7 = '1;

   logic [1:0]          ptr_q, ptr_d;
   logic                we_q, we_d;
   logic                r7en_q, r7en_d;
   logic [AW-1:0]       wr_q, wr_d;
   logic [DW-1:0]       din_q, din_d;
   logic [DW-1:0]       r7in_q, r7in_d;
   logic [(1<<AW)-1:0]  pend_q, pend_d;

   logic [2:0]          grant;
   logic [2:0]          cand;
   logic [1:0]          gidx;
   logic                xfer;
   logic [AW-1:0]       sel_addr;
   logic [DW-1:0]       sel_data;
   logic                cm_vld;
   logic [AW-1:0]       cm_addr;

   // Search ptr, ptr+1, ptr+2 (mod 3); first valid requester wins.
   always_comb begin
      grant    = '0;
      gidx     = 2'd0;
      xfer     = 1'b0;
      cand     = '0;
      sel_addr = '0;
      sel_data = '0;
      for (int k = 0; k < 3; k++) begin
         cand = {1'b0, ptr_q} + 3'(k);
         if (cand >= 3'd3) cand = cand - 3'd3;
         if (!xfer && req.req_valid[cand[1:0]]) begin
            xfer              = 1'b1;
            gidx              = cand[1:0];
            grant[cand[1:0]]  = 1'b1;
         end
      end
      for (int k = 0; k < 3; k++) begin
         if (gidx == 2'(k)) begin
            sel_addr = req.req_addr[k*AW +: AW];
            sel_data = req.req_data[k*DW +: DW];
         end
      end
   end

   assign req.req_ready = grant;

   always_comb begin
      ptr_d = ptr_q;
      if (xfer) ptr_d = (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
   end

   // Commit stage: exactly one enable pulses the cycle after a transfer.
   always_comb begin
      we_d   = 1'b0;
      r7en_d = 1'b0;
      wr_d   = wr_q;
      din_d  = din_q;
      r7in_d = r7in_q;
      if (xfer) begin
         if (sel_addr == R7) begin
            r7en_d = 1'b1;
            r7in_d = sel_data;
         end else begin
            we_d  = 1'b1;
            wr_d  = sel_addr;
            din_d = sel_data;
         end
      end
   end

   assign cm_vld  = we_q | r7en_q;
   assign cm_addr = r7en_q ? R7 : wr_q;

   // Claims are applied last so they win over both flush and commit clear.
   always_comb begin
      pend_d = pend_q;
      if (flush)       pend_d = '0;
      else if (cm_vld) pend_d[cm_addr] = 1'b0;
      if (claim_en)    pend_d[claim_addr] = 1'b1;
   end

   // A register being written this cycle is not a hazard: decode re-reads next cycle.
   always_comb begin
      stall = (use1 && pend_q[sr1] && !(cm_vld && cm_addr == sr1)) ||
              (use2 && pend_q[sr2] && !(cm_vld && cm_addr == sr2));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q  <= '0;
         we_q   <= 1'b0;
         r7en_q <= 1'b0;
         wr_q   <= '0;
         din_q  <= '0;
         r7in_q <= '0;
         pend_q <= '0;
      end else begin
         ptr_q  <= ptr_d;
         we_q   <= we_d;
         r7en_q <= r7en_d;
         wr_q   <= wr_d;
         din_q  <= din_d;
         r7in_q <= r7in_d;
         pend_q <= pend_d;
      end
   end

   assign write_en = we_q;
   assign wr       = wr_q;
   assign data_in  = din_q;
   assign R7_en    = r7en_q;
   assign R7_in    = r7in_q;
   assign pending  = pend_q;
endmodule

// File: tb/tb_regfile_wr_sched.sv
// Directed bench for regfile_wr_sched: arbitration, R7 steering, scoreboard and reset.
module tb_regfile_wr_sched;
   localparam int DW = 16;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          write_en, R7_en, stall;
   logic [AW-1:0] wr;
   logic [DW-1:0] data_in, R7_in;
   logic          claim_en, flush, use1, use2;
   logic [AW-1:0] claim_addr, sr1, sr2;
   logic [7:0]    pending;
   int            n_chk = 0;
   int            n_fail = 0;

   regfile_wr_sched_if #(.DW(DW), .AW(AW)) rq ();

   regfile_wr_sched #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .rst(rst), .req(rq.slave),
      .write_en(write_en), .wr(wr), .data_in(data_in),
      .R7_en(R7_en), .R7_in(R7_in),
      .claim_en(claim_en), .claim_addr(claim_addr), .flush(flush),
      .sr1(sr1), .sr2(sr2), .use1(use1), .use2(use2),
      .stall(stall), .pending(pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      rq.req_valid = '0;
      rq.req_addr  = {3'd3, 3'd2, 3'd1};
      rq.req_data  = {16'hA003, 16'hA002, 16'hA001};
      claim_en = 1'b0; claim_addr = '0; flush = 1'b0;
      sr1 = '0; sr2 = '0; use1 = 1'b0; use2 = 1'b0;
      tick(); tick();
      chk("rst_we", write_en, 0);
      chk("rst_r7en", R7_en, 0);
      chk("rst_wr", wr, 0);
      chk("rst_din", data_in, 0);
      chk("rst_r7in", R7_in, 0);
      chk("rst_pend", pending, 0);
      chk("rst_stall", stall, 0);
      rst = 1'b1;

      // Round robin with everyone valid
      rq.req_valid = 3'b111;
      for (int k = 0; k < 6; k++) begin
         #1;
         chk("rr_ready", rq.req_ready, 32'(1 << (k % 3)));
         tick();
         chk("rr_we", write_en, 1);
         chk("rr_wr", wr, 32'((k % 3) + 1));
         chk("rr_din", data_in, 32'(16'hA001 + (k % 3)));
      end
      rq.req_valid = '0;
      tick();
      chk("idle_we", write_en, 0);
      chk("idle_wr_hold", wr, 3);

      // R7 steering from requester 1
      rq.req_addr  = {3'd3, 3'd7, 3'd1};
      rq.req_data  = {16'hA003, 16'hBEEF, 16'hA001};
      rq.req_valid = 3'b010;
      #1;
      chk("r7_ready", rq.req_ready, 3'b010);
      tick();
      rq.req_valid = '0;
      chk("r7_en", R7_en, 1);
      chk("r7_in", R7_in, 16'hBEEF);
      chk("r7_we", write_en, 0);
      tick();
      chk("r7_en_off", R7_en, 0);

      // RAW hazard on r4 with commit-cycle bypass
      sr1 = 3'd4; use1 = 1'b1;
      #1;
      chk("hz_pre_stall", stall, 0);
      claim_en = 1'b1; claim_addr = 3'd4;
      tick();
      claim_en = 1'b0;
      chk("hz_pend", pending, 8'h10);
      chk("hz_stall", stall, 1);
      tick();
      chk("hz_stall2", stall, 1);
      rq.req_addr  = {3'd3, 3'd7, 3'd4};
      rq.req_data  = {16'hA003, 16'hBEEF, 16'h1234};
      rq.req_valid = 3'b001;
      #1;
      chk("hz_ready", rq.req_ready, 3'b001);
      chk("hz_stall3", stall, 1);
      tick();
      rq.req_valid = '0;
      #1;
      chk("hz_cm_we", write_en, 1);
      chk("hz_cm_wr", wr, 4);
      chk("hz_bypass", stall, 0);
      chk("hz_cm_pend", pending, 8'h10);
      tick();
      chk("hz_clr_pend", pending, 8'h00);
      chk("hz_clr_stall", stall, 0);
      use1 = 1'b0;

      // Claim r5 during the cycle r5 commits
      rq.req_addr  = {3'd3, 3'd7, 3'd5};
      rq.req_data  = {16'hA003, 16'hBEEF, 16'h5555};
      rq.req_valid = 3'b001;
      tick();
      rq.req_valid = '0;
      claim_en = 1'b1; claim_addr = 3'd5;
      #1;
      chk("col_we", write_en, 1);
      chk("col_wr", wr, 5);
      tick();
      claim_en = 1'b0;
      chk("col_pend", pending, 8'h20);

      // Flush with simultaneous claim and a write latched in the same cycle
      claim_en = 1'b1;
      claim_addr = 3'd4; tick();
      claim_addr = 3'd6; tick();
      claim_addr = 3'd7; tick();
      claim_en = 1'b0;
      chk("fl_pre_pend", pending, 8'hF0);
      rq.req_addr  = {3'd6, 3'd7, 3'd5};
      rq.req_data  = {16'h6666, 16'hBEEF, 16'h5555};
      rq.req_valid = 3'b100;
      flush = 1'b1; claim_en = 1'b1; claim_addr = 3'd2;
      #1;
      chk("fl_ready", rq.req_ready, 3'b100);
      tick();
      flush = 1'b0; claim_en = 1'b0; rq.req_valid = '0;
      chk("fl_pend", pending, 8'h04);
      chk("fl_we", write_en, 1);
      chk("fl_wr", wr, 6);
      chk("fl_din", data_in, 16'h6666);
      tick();
      chk("fl_we_off", write_en, 0);
      chk("fl_pend_hold", pending, 8'h04);
      sr2 = 3'd2; use2 = 1'b1;
      #1;
      chk("u2_stall", stall, 1);
      use2 = 1'b0;
      #1;
      chk("u2_nouse", stall, 0);

      // Asynchronous reset mid-stream
      rq.req_addr  = {3'd3, 3'd2, 3'd1};
      rq.req_data  = {16'hA003, 16'hA002, 16'hA001};
      rq.req_valid = 3'b111;
      sr1 = 3'd2; use1 = 1'b1;
      claim_en = 1'b1; claim_addr = 3'd3;
      tick();
      claim_en = 1'b0;
      chk("mr_we", write_en, 1);
      chk("mr_pend", pending, 8'h0C);
      chk("mr_stall", stall, 1);
      rst = 1'b0;
      #1;
      chk("ar_we", write_en, 0);
      chk("ar_wr", wr, 0);
      chk("ar_din", data_in, 0);
      chk("ar_pend", pending, 0);
      chk("ar_stall", stall, 0);
      tick();
      chk("ar_we_hold", write_en, 0);
      rst = 1'b1;
      #1;
      chk("ar_first_grant", rq.req_ready, 3'b001);
      tick();
      rq.req_valid = '0;
      chk("ar_post_we", write_en, 1);
      chk("ar_post_wr", wr, 1);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
